// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: hex segment table and
// the all-off patterns for segments and digit enables.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low codes with the dp bit off; element n is the pattern for hex digit n.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display bus between the CPU top level (master) and the scan driver (slave).
interface seg_scan_driver_if;
  logic [31:0] data_in;
  logic        data_valid;
  logic        hi_sel;
  logic [3:0]  dp_mask;
  logic [3:0]  AN;
  logic [7:0]  seg;

  modport master (output data_in, data_valid, hi_sel, dp_mask, input AN, seg);
  modport slave  (input data_in, data_valid, hi_sel, dp_mask, output AN, seg);
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low g..a segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);
  assign o_seg = HEX_SEG[i_nibble][6:0];
endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit time-multiplexed seven-segment driver with shadowed display word.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  seg_scan_driver_if.slave disp
);

  localparam int unsigned   PW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;
  logic [31:0]   r_shadow;
  logic [3:0]    r_an;
  logic [7:0]    r_seg;

  logic [15:0]   w_half;
  logic [15:0]   w_upper;
  logic [3:0]    w_nibble;
  logic [6:0]    w_hex;
  logic          w_blank;

  assign w_half   = disp.hi_sel ? r_shadow[31:16] : r_shadow[15:0];
  // Nibbles idx..3 of the selected half, right-aligned.
  assign w_upper  = w_half >> {r_idx, 2'b00};
  assign w_nibble = w_upper[3:0];

  seg_hex_decode u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_hex)
  );

`ifdef SEG_LZ_BLANK_EN
  assign w_blank = (r_idx != 2'd0) && (w_upper == '0) && !disp.dp_mask[r_idx];
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_an     <= AN_OFF;
      r_seg    <= SEG_BLANK;
    end else begin
      if (r_pre == PRE_LAST) begin
        r_pre <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_pre <= r_pre + PW'(1);
      end

      if (disp.data_valid)
        r_shadow <= disp.data_in;

      // Outputs always reflect the pre-edge index, so a digit change lands one edge later.
      if (w_blank) begin
        r_an  <= AN_OFF;
        r_seg <= SEG_BLANK;
      end else begin
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= {~disp.dp_mask[r_idx], w_hex};
      end
    end
  end

  assign disp.AN  = r_an;
  assign disp.seg = r_seg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with a cycle-count based reference model.
module tb_seg_scan_driver;
  localparam int unsigned SD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  seg_scan_driver_if bus ();

  seg_scan_driver #(.SCAN_DIV(SD)) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference: digit shown at an edge is (edges since reset / SD) mod 4.
  int unsigned m_t;
  logic [31:0] m_sh;
  logic [3:0]  m_an;
  logic [7:0]  m_seg;

  always @(posedge clk) begin
    int unsigned d;
    logic [15:0] w;
    logic [15:0] up;
    bit          blank;
    if (rst) begin
      m_t = 0; m_sh = 0; m_an = 4'hF; m_seg = 8'hFF;
    end else begin
      d  = (m_t / SD) % 4;
      w  = bus.hi_sel ? m_sh[31:16] : m_sh[15:0];
      up = w >> (4 * d);
      blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
      blank = (d != 0) && (up == 16'd0) && !bus.dp_mask[d];
`endif
      if (blank) begin
        m_an = 4'hF; m_seg = 8'hFF;
      end else begin
        m_an  = 4'hF & ~(4'b0001 << d);
        m_seg = HEX[up[3:0]] & (bus.dp_mask[d] ? 8'h7F : 8'hFF);
      end
      m_t = m_t + 1;
      if (bus.data_valid) m_sh = bus.data_in;
    end
  end

  task automatic do_reset();
    rst = 1'b1; bus.data_valid = 1'b0; bus.data_in = '0; bus.hi_sel = 1'b0; bus.dp_mask = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.data_valid = 1'b0; bus.data_in = '0; bus.hi_sel = 1'b0; bus.dp_mask = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.AN !== 4'hF) begin errors++; $display("FAIL reset_an got=%h exp=F", bus.AN); end
    checks++; if (bus.seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got=%h exp=FF", bus.seg); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.AN !== 4'hE) begin errors++; $display("FAIL release_an got=%h exp=E", bus.AN); end
    checks++; if (bus.seg !== 8'hC0) begin errors++; $display("FAIL release_seg got=%h exp=C0", bus.seg); end
  endtask

  task automatic test_scan_order();
    logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] sg_tab [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    int d;
    do_reset();
    bus.data_in = 32'h0000_1234; bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    for (int c = 2; c <= 21; c++) begin
      @(negedge clk);
      d = ((c - 1) / 4) % 4;
      checks++;
      if (bus.AN !== an_tab[d] || bus.seg !== sg_tab[d]) begin
        errors++; $display("FAIL scan_order c=%0d got=%h/%h exp=%h/%h", c, bus.AN, bus.seg, an_tab[d], sg_tab[d]);
      end
      checks++;
      if (bus.AN !== m_an || bus.seg !== m_seg) begin
        errors++; $display("FAIL scan_model c=%0d got=%h/%h exp=%h/%h", c, bus.AN, bus.seg, m_an, m_seg);
      end
    end
  endtask

  task automatic test_half_select();
    logic [7:0] exp;
    do_reset();
    bus.data_in = 32'hABCD_0000; bus.data_valid = 1'b1; bus.hi_sel = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      case (bus.AN)
        4'hE: exp = 8'hA1;
        4'hD: exp = 8'hC6;
        4'hB: exp = 8'h83;
        4'h7: exp = 8'h88;
        default: exp = 8'hXX;
      endcase
      checks++;
      if (bus.seg !== exp) begin errors++; $display("FAIL half_hi an=%h got=%h exp=%h", bus.AN, bus.seg, exp); end
    end
    bus.hi_sel = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
`ifndef SEG_LZ_BLANK_EN
      checks++;
      if (bus.seg !== 8'hC0) begin errors++; $display("FAIL half_lo got=%h exp=C0", bus.seg); end
`endif
      checks++;
      if (bus.AN !== m_an || bus.seg !== m_seg) begin
        errors++; $display("FAIL half_model got=%h/%h exp=%h/%h", bus.AN, bus.seg, m_an, m_seg);
      end
    end
  endtask

  task automatic test_dp();
    do_reset();
    bus.dp_mask = 4'b0101;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
`ifndef SEG_LZ_BLANK_EN
      checks++;
      if (bus.seg !== ((bus.AN == 4'hE || bus.AN == 4'hB) ? 8'h40 : 8'hC0)) begin
        errors++; $display("FAIL dp an=%h got=%h", bus.AN, bus.seg);
      end
`endif
      checks++;
      if (bus.AN !== m_an || bus.seg !== m_seg) begin
        errors++; $display("FAIL dp_model got=%h/%h exp=%h/%h", bus.AN, bus.seg, m_an, m_seg);
      end
    end
  endtask

  task automatic test_latch_hold();
    int n;
    do_reset();
    bus.data_in = 32'h0000_FFFF; bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0; bus.data_in = $urandom;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      bus.data_in = $urandom;
      checks++;
      if (bus.seg !== 8'h8E) begin errors++; $display("FAIL hold got=%h exp=8E", bus.seg); end
    end
    n = 0;
    while (n < SD + 1 && (m_t % SD) != SD - 1) begin
      @(negedge clk); n++;
    end
    checks++;
    if ((m_t % SD) != SD - 1) begin errors++; $display("FAIL wrap_align got=%0d exp=%0d", m_t % SD, SD - 1); end
    bus.data_in = 32'h1111_1111; bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    checks++;
    if (bus.seg !== 8'h8E) begin errors++; $display("FAIL wrap_old got=%h exp=8E", bus.seg); end
    @(negedge clk);
    checks++;
    if (bus.seg !== 8'hF9) begin errors++; $display("FAIL wrap_new got=%h exp=F9", bus.seg); end
    checks++;
    if (bus.AN !== m_an) begin errors++; $display("FAIL wrap_an got=%h exp=%h", bus.AN, m_an); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.data_in = 32'h8765_4321; bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.AN !== 4'hF || bus.seg !== 8'hFF) begin
      errors++; $display("FAIL mid_reset got=%h/%h exp=F/FF", bus.AN, bus.seg);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.AN !== 4'hE || bus.seg !== 8'hC0) begin
      errors++; $display("FAIL mid_release got=%h/%h exp=E/C0", bus.AN, bus.seg);
    end
  endtask

`ifdef SEG_LZ_BLANK_EN
  task automatic test_lz_blank();
    int off_cnt;
    do_reset();
    bus.data_in = 32'h0000_0050; bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    @(negedge clk);
    off_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus.AN == 4'hF) off_cnt++;
      checks++;
      if (!((bus.AN == 4'hF && bus.seg == 8'hFF) || (bus.AN == 4'hD && bus.seg == 8'h92) ||
            (bus.AN == 4'hE && bus.seg == 8'hC0))) begin
        errors++; $display("FAIL lz_pattern got=%h/%h", bus.AN, bus.seg);
      end
    end
    checks++;
    if (off_cnt != 8) begin errors++; $display("FAIL lz_blank_slots got=%0d exp=8", off_cnt); end
    bus.dp_mask = 4'b1000;
    off_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus.AN == 4'h7 && bus.seg == 8'h40) off_cnt++;
      checks++;
      if (bus.AN !== m_an || bus.seg !== m_seg) begin
        errors++; $display("FAIL lz_model got=%h/%h exp=%h/%h", bus.AN, bus.seg, m_an, m_seg);
      end
    end
    checks++;
    if (off_cnt != 4) begin errors++; $display("FAIL lz_dp3 got=%0d exp=4", off_cnt); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] w;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks++;
      if (bus.AN !== m_an || bus.seg !== m_seg) begin
        errors++; $display("FAIL random c=%0d got=%h/%h exp=%h/%h", c, bus.AN, bus.seg, m_an, m_seg);
      end
      rst = ($urandom_range(0, 99) == 0);
      w = $urandom;
      for (int k = 0; k < 8; k++) if ($urandom_range(0, 1) == 1) w[4*k +: 4] = 4'h0;
      bus.data_in    = w;
      bus.data_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) bus.hi_sel  = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0)  bus.dp_mask = 4'($urandom_range(0, 15));
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.data_in = '0; bus.data_valid = 1'b0; bus.hi_sel = 1'b0; bus.dp_mask = '0;
    test_reset();
    test_scan_order();
    test_half_select();
    test_dp();
    test_latch_hold();
    test_reset_mid();
`ifdef SEG_LZ_BLANK_EN
    test_lz_blank();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed four-digit seven-segment driver that consumes the CPU's 32-bit display word and 4-bit flag register and drives the board's AN/seg pins. It latches a word on a valid strobe, shows the selected 16-bit half as four hex digits, lights decimal points from the flag bits, and refreshes one digit every SCAN_DIV clocks. It sits between the CPU top-level outputs and the FPGA display pins.

## Interface
- SCAN_DIV, 50000: clocks per digit slot; legal range ≥2.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  32  display word from CPU.
- data_valid  in  1  latch data_in into the shadow register this cycle.
- hi_sel  in  1  0: show shadow[15:0]; 1: show shadow[31:16]; not latched.
- dp_mask  in  4  per-digit decimal point enable (CPU FR flags); bit i → digit i.
- AN  out  4  digit enables, active-low, one-hot; AN[0] = rightmost digit = nibble 0.
- seg  out  8  active-low segments; seg[6:0] = g..a, seg[7] = dp.

## Operation
- State: prescaler (width $clog2(SCAN_DIV)), 2-bit digit index, 32-bit shadow, registered AN/seg.
- Prescaler counts 0..SCAN_DIV-1, wraps to 0; on the wrap edge the index advances 0→1→2→3→0.
- data_valid sampled high at an edge: shadow ← data_in at that edge. Low: shadow holds.
- Each edge, AN/seg are reloaded from current index, shadow, hi_sel, dp_mask: AN = ~(1<<index); seg[6:0] = hex decode of nibble index of the selected half; seg[7] = ~dp_mask[index].
- Hex codes (dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Reset values: prescaler 0, index 0, shadow 0, AN = 4'hF, seg = 8'hFF (all off).
- Reset mid-scan: all state returns to reset values at that edge; previously latched word is lost.

## Timing
- data_valid high at edge k → shadow updated at edge k → seg reflects new value at edge k+1 (while the matching digit is active).
- Index change at edge k → AN/seg for the new digit at edge k+1; each digit driven exactly SCAN_DIV cycles; frame = 4·SCAN_DIV cycles.
- data_valid coinciding with a prescaler wrap: both take effect at that edge; next edge shows the new digit with the new word.
- hi_sel/dp_mask changes visible at the next edge; no glitch filtering.
- First edge after rst deasserts: AN = 4'b1110, seg = 8'hC0.
- Exactly one AN bit low at all times outside reset.

## Configuration
- SEG_LZ_BLANK_EN defined: leading-zero blanking. Digit i (i = 3,2,1) is blanked (its AN bit stays high for its slot, seg = 8'hFF) when nibbles i..3 of the selected half are all zero and dp_mask[i] = 0. Digit 0 never blanked. Scan timing unchanged.
- Undefined: all four digits always displayed, zeros included.

## Structure
- Package seg_pkg: hex-to-segment constant table, SEG_BLANK = 8'hFF, AN_OFF = 4'hF.
- One sub-module seg_hex_decode: combinational 4-bit nibble → 7-bit active-low pattern using seg_pkg table; instantiated once on the selected nibble.

## Test plan
- Reset: rst high 3 cycles → AN = F, seg = FF; release → next edge AN = E, seg = C0.
- Scan order (SCAN_DIV = 4), data 0x0000_1234 valid, hi_sel = 0 → AN/seg cycle E/99, D/B0, B/A4, 7/F9, each held 4 clocks, repeating.
- Half select: data 0xABCD_0000, hi_sel = 1 → digits show D(A1), C(C6), b(83), A(88); hi_sel = 0 → all C0.
- Decimal points: dp_mask = 4'b0101, data 0 → digits 0,2 show seg = 40, digits 1,3 show C0.
- Latch/hold: data_valid one cycle with 0x0000_FFFF, then data_in changes with valid low → display stays 8E on all digits; valid coincident with prescaler wrap → new word on next edge.
- SEG_LZ_BLANK_EN: data 0x0000_0050 → digits 3,2 AN high/seg FF, digit 1 = 92, digit 0 = C0; dp_mask[3]=1 → digit 3 shows 40; rst mid-scan → AN = F next edge.
